// File: rtl/counter_updown_mod.sv
// Parameterised up/down counter with wrap or saturate at the bounds, parallel
// load with clamp to MAX, and an optional one-shot mode that parks in DONE.
module counter_updown_mod #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 2**W - 1,
  parameter bit          SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         en,
  input  logic         up,
  input  logic         mode_os,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         wrap,
  output logic         sat_flag,
  output logic         done
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         wrap_q,  wrap_d;
  logic         sat_q,   sat_d;
  logic         at_bound;
  logic [W-1:0] din_clamped;

  // Bound in the currently selected direction; also drives tc.
  assign at_bound    = up ? (count_q == MAX_V) : (count_q == '0);
  assign din_clamped = (din > MAX_V) ? MAX_V : din;

  // Next-state: clr > load > enabled count > hold (rst handled in the register).
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    state_d = state_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
      state_d = ST_RUN;
    end else if (load) begin
      count_d = din_clamped;
      state_d = ST_RUN;
    end else if (en && (state_q == ST_RUN)) begin
      if (!at_bound) begin
        count_d = up ? (count_q + W'(1)) : (count_q - W'(1));
      end else begin
        if (SAT) begin
          sat_d = 1'b1;
        end else begin
          count_d = up ? '0 : MAX_V;
          wrap_d  = 1'b1;
        end
        if (mode_os) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      state_q <= state_d;
    end
  end

  assign count    = count_q;
  assign tc       = at_bound;
  assign wrap     = wrap_q;
  assign sat_flag = sat_q;
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: wrapping (SAT=0) and saturating (SAT=1)
// instances, W=4 MAX=9, driven together and compared to an integer model.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       rst, clr, load, en, up, mode_os;
  logic [3:0] din;

  logic [3:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, wrap_w, wrap_s, sat_w, sat_s, done_w, done_s;

  int checks = 0;
  int fails  = 0;

  // Model state per instance: index 0 wraps, index 1 saturates.
  int m_cnt[2];
  int m_wrap[2];
  int m_sat[2];
  int m_done[2];

  always #5 clk = ~clk;

  counter_updown_mod #(.W(4), .MAX(9), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .mode_os(mode_os), .count(cnt_w), .tc(tc_w), .wrap(wrap_w),
    .sat_flag(sat_w), .done(done_w)
  );

  counter_updown_mod #(.W(4), .MAX(9), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .mode_os(mode_os), .count(cnt_s), .tc(tc_s), .wrap(wrap_s),
    .sat_flag(sat_s), .done(done_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural next-state for one instance from the sampled inputs.
  task automatic model_step(input int k);
    int c;
    c = m_cnt[k];
    m_wrap[k] = 0;
    if (rst) begin
      c = 0; m_sat[k] = 0; m_done[k] = 0;
    end else if (clr) begin
      c = 0; m_sat[k] = 0; m_done[k] = 0;
    end else if (load) begin
      c = (int'(din) > 9) ? 9 : int'(din);
      m_done[k] = 0;
    end else if (en && !m_done[k]) begin
      if (up && c < 9) c = c + 1;
      else if (!up && c > 0) c = c - 1;
      else begin
        if (k == 1) m_sat[k] = 1;
        else begin
          c = up ? 0 : 9;
          m_wrap[k] = 1;
        end
        if (mode_os) m_done[k] = 1;
      end
    end
    m_cnt[k] = c;
  endtask

  task automatic check_all(input string tag);
    int exp_tc_w, exp_tc_s;
    exp_tc_w = up ? int'(m_cnt[0] == 9) : int'(m_cnt[0] == 0);
    exp_tc_s = up ? int'(m_cnt[1] == 9) : int'(m_cnt[1] == 0);
    check({tag, ".w.count"}, int'(cnt_w),  m_cnt[0]);
    check({tag, ".w.wrap"},  int'(wrap_w), m_wrap[0]);
    check({tag, ".w.sat"},   int'(sat_w),  m_sat[0]);
    check({tag, ".w.done"},  int'(done_w), m_done[0]);
    check({tag, ".w.tc"},    int'(tc_w),   exp_tc_w);
    check({tag, ".s.count"}, int'(cnt_s),  m_cnt[1]);
    check({tag, ".s.wrap"},  int'(wrap_s), m_wrap[1]);
    check({tag, ".s.sat"},   int'(sat_s),  m_sat[1]);
    check({tag, ".s.done"},  int'(done_s), m_done[1]);
    check({tag, ".s.tc"},    int'(tc_s),   exp_tc_s);
  endtask

  // One clock: drive at negedge, update model, sample 1 time unit after posedge.
  task automatic cyc(input string tag, input bit r, input bit c, input bit l,
                     input int d, input bit e, input bit u, input bit m);
    @(negedge clk);
    rst = r; clr = c; load = l; din = 4'(d); en = e; up = u; mode_os = m;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; din = '0; en = 1'b0; up = 1'b1; mode_os = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_wrap[k] = 0; m_sat[k] = 0; m_done[k] = 0;
    end

    // Reset state
    cyc("reset", 1, 0, 0, 0, 0, 1, 0);
    check("reset.count_const", int'(cnt_w), 0);

    // Free-run up through the 9->0 wrap
    for (int i = 0; i < 12; i++) begin
      cyc("freerun_up", 0, 0, 0, 0, 1, 1, 0);
      if (i == 8) check("freerun_up.tc_at9", int'(tc_w), 1);
      if (i == 9) check("freerun_up.wrap_pulse", int'(wrap_w), 1);
      if (i == 10) check("freerun_up.wrap_clear", int'(wrap_w), 0);
    end
    check("freerun_up.final", int'(cnt_w), 2);

    // Down wrap from load 1
    cyc("down_load", 0, 0, 1, 1, 0, 0, 0);
    cyc("down_to0", 0, 0, 0, 0, 1, 0, 0);
    check("down.tc_at0", int'(tc_w), 1);
    cyc("down_wrap", 0, 0, 0, 0, 1, 0, 0);
    check("down.wrap_to9", int'(cnt_w), 9);
    check("down.wrap_pulse", int'(wrap_w), 1);

    // Load clamp beats en; clr beats load
    cyc("load_clamp", 0, 0, 1, 15, 1, 1, 0);
    check("load_clamp.const", int'(cnt_w), 9);
    cyc("clr_over_load", 0, 1, 1, 5, 1, 1, 0);
    check("clr_over_load.const", int'(cnt_w), 0);

    // Saturation on the SAT=1 instance; mid-count direction change
    cyc("sat_load8", 0, 0, 1, 8, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("sat_up", 0, 0, 0, 0, 1, 1, 0);
    check("sat.count_const", int'(cnt_s), 9);
    check("sat.flag_const", int'(sat_s), 1);
    cyc("sat_dir_change", 0, 0, 0, 0, 1, 0, 0);
    check("sat.dir_change", int'(cnt_s), 8);
    check("sat.flag_sticky", int'(sat_s), 1);
    cyc("sat_clr", 0, 1, 0, 0, 0, 1, 0);
    check("sat.clr_flag", int'(sat_s), 0);

    // One-shot run to DONE, hold, reload resumes
    for (int i = 0; i < 10; i++) cyc("os_run", 0, 0, 0, 0, 1, 1, 1);
    check("os.done_const", int'(done_w), 1);
    check("os.count_const", int'(cnt_w), 0);
    for (int i = 0; i < 3; i++) cyc("os_hold", 0, 0, 0, 0, 1, i[0], 1);
    cyc("os_reload", 0, 0, 1, 3, 1, 1, 1);
    check("os.reload_done", int'(done_w), 0);
    cyc("os_resume", 0, 0, 0, 0, 1, 1, 1);
    check("os.resume_const", int'(cnt_w), 4);

    // Mid-run reset from count 5 in RUN, and from DONE
    cyc("mr_load5", 0, 0, 1, 5, 0, 1, 0);
    cyc("mr_rst_run", 1, 1, 1, 7, 1, 1, 0);
    cyc("mr_resume", 0, 0, 0, 0, 1, 1, 0);
    check("mr.resume_const", int'(cnt_w), 1);
    cyc("mr_load9", 0, 0, 1, 9, 0, 1, 1);
    cyc("mr_to_done", 0, 0, 0, 0, 1, 1, 1);
    cyc("mr_rst_done", 1, 0, 0, 0, 1, 1, 1);
    check("mr.done_cleared", int'(done_w), 0);
    cyc("mr_resume2", 0, 0, 0, 0, 1, 1, 1);

    // Randomised stimulus against the model
    for (int i = 0; i < 400; i++) begin
      cyc("random",
          ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 11) == 0),
          int'($urandom_range(0, 15)),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
